// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and the
// bit positions of CPOL/CPHA inside the 2-bit spi_mode word.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period timer, SCLK edge counter, the registered SCLK
// and the leading/trailing edge strobes consumed by the master's shifters.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DIV_W  = 8,
  localparam int EDGE_W = $clog2(2 * DATA_W)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  spi_state_t       i_state,
  input  logic             i_accept,
  input  logic [DIV_W-1:0] i_clk_div,
  input  logic             i_cpol,
  output logic             o_tick,
  output logic             o_lead,
  output logic             o_trail,
  output logic             o_first,
  output logic             o_last,
  output logic             o_sclk
);

  logic [DIV_W-1:0]  r_timer;
  logic [DIV_W-1:0]  r_half;
  logic [EDGE_W-1:0] r_edge;
  logic              r_sclk;
  logic              w_tick;
  logic              w_xfer_tick;

  assign w_tick      = (i_state != IDLE) && (r_timer == '0);
  assign w_xfer_tick = w_tick && (i_state == XFER);

  // The timer reloads to H-1 (the latched divider) on every tick, so each
  // phase of the transfer lasts a whole number of SCLK half-periods.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
      r_half  <= '0;
    end else if (i_state == IDLE) begin
      if (i_accept) begin
        r_timer <= i_clk_div;
        r_half  <= i_clk_div;
      end
    end else if (w_tick) begin
      r_timer <= r_half;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // In IDLE the clock tracks the live CPOL so the line already rests at the
  // right level when a transfer is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge <= '0;
      r_sclk <= 1'b0;
    end else if (i_state == IDLE) begin
      r_sclk <= i_cpol;
      if (i_accept) begin
        r_edge <= '0;
      end
    end else if (w_xfer_tick) begin
      r_sclk <= ~r_sclk;
      r_edge <= r_edge + 1'b1;
    end
  end

  assign o_tick  = w_tick;
  assign o_lead  = w_xfer_tick && !r_edge[0];
  assign o_trail = w_xfer_tick && r_edge[0];
  assign o_first = (r_edge == '0);
  assign o_last  = (r_edge == EDGE_W'(2 * DATA_W - 1));
  assign o_sclk  = r_sclk;

endmodule

// File: rtl/spi_master_v2.sv
// SPI master with start/ready/done handshake, programmable SCLK divider and
// all four CPOL/CPHA modes. Define SPI_LSB_FIRST_EN to add the lsb_first input.
module spi_master_v2
  import spi_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NUM_SS = 4,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_din,
  input  logic [SEL_W-1:0]  i_slave_sel,
  input  logic [1:0]        i_spi_mode,
  input  logic [DIV_W-1:0]  i_clk_div,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb_first,
`endif
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_dout,
  output logic [NUM_SS-1:0] o_ss,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso
);

  spi_state_t        r_state;
  spi_state_t        w_next;
  logic              w_accept;
  logic              w_capture;
  logic              w_tick;
  logic              w_lead;
  logic              w_trail;
  logic              w_first;
  logic              w_last;
  logic              w_sample;
  logic              w_shift;
  logic              w_lsb;
  logic [NUM_SS-1:0] w_ss_dec;

  logic              r_ready;
  logic              r_done;
  logic              r_cpha;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic [NUM_SS-1:0] r_ss;

  spi_clk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_clk_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_state   (r_state),
    .i_accept  (w_accept),
    .i_clk_div (i_clk_div),
    .i_cpol    (i_spi_mode[CPOL_BIT]),
    .o_tick    (w_tick),
    .o_lead    (w_lead),
    .o_trail   (w_trail),
    .o_first   (w_first),
    .o_last    (w_last),
    .o_sclk    (o_sclk)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next   = SETUP;
          w_accept = 1'b1;
        end
      end
      SETUP: if (w_tick) w_next = XFER;
      XFER:  if (w_tick && w_last) w_next = HOLD;
      HOLD: begin
        if (w_tick) begin
          w_next    = GAP;
          w_capture = 1'b1;
        end
      end
      GAP:     if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // An out-of-range select matches no index, so every line stays high.
  always_comb begin
    w_ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (i_slave_sel == SEL_W'(i)) begin
        w_ss_dec[i] = 1'b0;
      end
    end
  end

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lsb <= 1'b0;
    end else if (w_accept) begin
      r_lsb <= i_lsb_first;
    end
  end

  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif

  // CPHA=1 skips the shift on the very first edge; CPHA=0 skips the last.
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? (w_lead && !w_first) : (w_trail && !w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_cpha <= 1'b0;
      r_ss   <= '1;
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_accept) begin
        r_tx   <= i_din;
        r_rx   <= '0;
        r_cpha <= i_spi_mode[CPHA_BIT];
        r_ss   <= w_ss_dec;
      end else begin
        if (w_sample) begin
          r_rx <= w_lsb ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};
        end
        if (w_shift) begin
          r_tx <= w_lsb ? (r_tx >> 1) : (r_tx << 1);
        end
        if (w_capture) begin
          r_ss   <= '1;
          r_dout <= r_rx;
        end
      end
    end
  end

  assign o_mosi  = ((r_state == SETUP) || (r_state == XFER) || (r_state == HOLD)) ?
                   (w_lsb ? r_tx[0] : r_tx[DATA_W-1]) : 1'b0;
  assign o_ready = r_ready;
  assign o_busy  = ~r_ready;
  assign o_done  = r_done;
  assign o_dout  = r_dout;
  assign o_ss    = r_ss;

endmodule

// File: tb/tb_spi_master_v2.sv
// Self-checking bench for spi_master_v2: a behavioural SPI slave plus
// transfer-level expectations (latency, select timing, round-trip data).
module tb_spi_master_v2;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [7:0] din;
  logic [1:0] slaveSel;
  logic [1:0] spiMode;
  logic [7:0] clkDiv;
  logic       miso = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic       lsbFirst = 1'b0;
`endif

  logic       ready4, busy4, done4, sclk4, mosi4;
  logic [7:0] dout4;
  logic [3:0] ss4;
  logic       ready3, busy3, done3, sclk3, mosi3;
  logic [7:0] dout3;
  logic [2:0] ss3;

  int errors = 0;
  int checks = 0;

  // Slave model state; the initial block only writes the control fields.
  logic [7:0] slvWord;
  logic       slvCpol;
  logic       slvCpha;
  logic       slvEnable = 1'b0;
  int         slvGo = 0;
  int         slvGoSeen = 0;
  logic [7:0] slvTx;
  logic [7:0] slvRx;
  logic       mosiAtNeg;
  int         mosiGlitch = 0;
  int         doneCount = 0;

  always #5 clk = ~clk;

  spi_master_v2 #(.DATA_W(DW), .NUM_SS(4), .DIV_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (start),
    .i_din       (din),
    .i_slave_sel (slaveSel),
    .i_spi_mode  (spiMode),
    .i_clk_div   (clkDiv),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first (lsbFirst),
`endif
    .o_ready     (ready4),
    .o_busy      (busy4),
    .o_done      (done4),
    .o_dout      (dout4),
    .o_ss        (ss4),
    .o_sclk      (sclk4),
    .o_mosi      (mosi4),
    .i_miso      (miso)
  );

  spi_master_v2 #(.DATA_W(DW), .NUM_SS(3), .DIV_W(8)) dut3 (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (start),
    .i_din       (din),
    .i_slave_sel (slaveSel),
    .i_spi_mode  (spiMode),
    .i_clk_div   (clkDiv),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first (lsbFirst),
`endif
    .o_ready     (ready3),
    .o_busy      (busy3),
    .o_done      (done3),
    .o_dout      (dout3),
    .o_ss        (ss3),
    .o_sclk      (sclk3),
    .o_mosi      (mosi3),
    .i_miso      (miso)
  );

  always @(negedge clk) begin
    mosiAtNeg <= mosi4;
    if (done4 === 1'b1) doneCount++;
  end

  // Mode-matched slave: samples MOSI on its sample edge, drives MISO on the
  // opposite edge (CPHA=0 presents the MSB as soon as it is armed).
  always @(sclk4 or slvGo) begin
    if (slvGo != slvGoSeen) begin
      slvGoSeen = slvGo;
      slvRx = '0;
      if (slvCpha == 1'b0) begin
        miso  = slvWord[DW-1];
        slvTx = slvWord << 1;
      end else begin
        slvTx = slvWord;
      end
    end else if (slvEnable) begin
      if ((sclk4 !== slvCpol) == (slvCpha == 1'b0)) begin
        slvRx = {slvRx[DW-2:0], mosi4};
        if (mosi4 !== mosiAtNeg) mosiGlitch++;
      end else begin
        miso  = slvTx[DW-1];
        slvTx = slvTx << 1;
      end
    end
  end

  function automatic int ssMask(input int sel, input int nss);
    int m;
    m = (1 << nss) - 1;
    if (sel < nss) m = m & ~(1 << sel);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] txWord, input logic [1:0] sel,
                               input logic [1:0] mode, input logic [7:0] div,
                               input logic [7:0] slaveWord, input bit midPulse);
    int h, lat, cycles, ssBad, ss3Bad, hsBad, d3Bad, readyDelay, donesBefore;
    bit gotDone;
    logic [7:0] gotDout4, gotDout3;
    h = int'(div) + 1;
    lat = (2 * DW + 2) * h + 1;
    ssBad = 0; ss3Bad = 0; hsBad = 0; d3Bad = 0; gotDone = 0;
    gotDout4 = '0; gotDout3 = '0;
    @(negedge clk);
    din = txWord; slaveSel = sel; spiMode = mode; clkDiv = div;
    repeat (2) @(negedge clk);
    checkOutput("idle_sclk_cpol", sclk4, mode[1]);
    checkOutput("ready_before", ready4, 1'b1);
    slvWord = slaveWord; slvCpol = mode[1]; slvCpha = mode[0];
    slvEnable = 1'b1; slvGo++;
    donesBefore = doneCount;
    start = 1'b1;
    cycles = 0;
    while (!gotDone && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        din = 8'($urandom); slaveSel = 2'($urandom);
        spiMode = 2'($urandom); clkDiv = 8'($urandom);
      end
      if (midPulse && cycles == lat / 2) begin start = 1'b1; din = 8'hFF; end
      if (midPulse && cycles == lat / 2 + 1) start = 1'b0;
      if (ss4 !== 4'(ssMask(sel, 4)) && cycles < lat) ssBad++;
      if (ss4 !== 4'hF && cycles >= lat) ssBad++;
      if ({1'b0, ss3} !== 4'(cycles < lat ? ssMask(sel, 3) : 7)) ss3Bad++;
      if (busy4 !== ~ready4) hsBad++;
      if (done3 !== done4) d3Bad++;
      if (done4 === 1'b1) begin
        gotDone = 1'b1; gotDout4 = dout4; gotDout3 = dout3;
      end
    end
    slvEnable = 1'b0;
    checkOutput("done_seen", gotDone, 1'b1);
    checkOutput("done_latency", cycles, lat);
    checkOutput("dout", gotDout4, slaveWord);
    checkOutput("dout_nss3", gotDout3, slaveWord);
    checkOutput("mosi_word", slvRx, txWord);
    checkOutput("ss_pattern", ssBad, 0);
    checkOutput("ss_pattern_nss3", ss3Bad, 0);
    checkOutput("busy_not_ready", hsBad, 0);
    checkOutput("done_nss3", d3Bad, 0);
    checkOutput("mosi_stable", mosiGlitch, 0);
    readyDelay = 0;
    while (ready4 !== 1'b1 && readyDelay < 600) begin
      @(negedge clk);
      readyDelay++;
    end
    checkOutput("gap_length", readyDelay, h);
    checkOutput("ready_nss3", ready3, 1'b1);
    checkOutput("done_once", doneCount - donesBefore, 1);
  endtask

  initial begin
    int donesBefore;
    rstN = 1'b0; start = 1'b0; din = '0; slaveSel = '0; spiMode = '0; clkDiv = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ss", ss4, 4'hF);
    checkOutput("rst_sclk", sclk4, 1'b0);
    checkOutput("rst_mosi", mosi4, 1'b0);
    checkOutput("rst_dout", dout4, 8'h00);
    checkOutput("rst_done", done4, 1'b0);
    checkOutput("rst_ready", ready4, 1'b0);
    checkOutput("rst_busy", busy4, 1'b1);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", ready4, 1'b1);
    checkOutput("busy_after_rst", busy4, 1'b0);

    $display("[TB] handshake");
    applyStimulus(8'hA5, 2'd2, 2'd0, 8'd1, 8'h3C, 1'b0);

    $display("[TB] reset mid-transfer");
    @(negedge clk);
    din = 8'h5A; slaveSel = 2'd1; spiMode = 2'd0; clkDiv = 8'd1;
    repeat (2) @(negedge clk);
    slvWord = 8'h99; slvCpol = 1'b0; slvCpha = 1'b0; slvEnable = 1'b1; slvGo++;
    donesBefore = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("sclk_high_mid_xfer", sclk4, 1'b1);
    slvEnable = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_ss", ss4, 4'hF);
    checkOutput("midrst_sclk", sclk4, 1'b0);
    checkOutput("midrst_dout", dout4, 8'h00);
    checkOutput("midrst_ready", ready4, 1'b0);
    checkOutput("midrst_busy", busy4, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_done", doneCount - donesBefore, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_again", ready4, 1'b1);
    applyStimulus(8'h5A, 2'd1, 2'd0, 8'd1, 8'h96, 1'b0);

    $display("[TB] all four modes");
    for (int m = 0; m < 4; m++) begin
      applyStimulus(8'hC3, 2'(m), 2'(m), 8'(m == 3 ? 0 : m), 8'($urandom), 1'b0);
    end

    $display("[TB] start while busy");
    applyStimulus(8'h12, 2'd0, 2'd0, 8'd1, 8'h6E, 1'b1);

    $display("[TB] out-of-range select");
    applyStimulus(8'h7E, 2'd3, 2'd1, 8'd2, 8'hB4, 1'b0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(8'($urandom), 2'($urandom), 2'($urandom),
                    8'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
